lsu_mem_access: RTL and testbench
=================================

# lsu_mem_access

Load/store unit for the MEM stage. Decodes RISC-V load/store width from funct3, checks alignment, and drives word-aligned read/write requests to the AHB master interface downstream. Sub-word stores become a read-modify-write sequence because the bus side performs only 32-bit transfers. Holds the pipeline through stallreq_o and returns an extracted, sign- or zero-extended load result to the MEM/WB register.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; only 32 is supported
- clk  in  1  single clock; everything is sampled on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- mem_re_i  in  1  load request from EX/MEM register
- mem_we_i  in  1  store request from EX/MEM register
- mem_funct3_i  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- mem_addr_i  in  ADDR_W  byte address
- mem_wdata_i  in  DATA_W  store data, right-aligned
- stall_i  in  6  pipeline stall vector from ctrl; bit 4 = MEM stage held
- stallreq_o  out  1  request to hold the pipeline
- load_data_o  out  DATA_W  registered, extended load result
- load_valid_o  out  1  one-cycle pulse, load_data_o newly updated
- err_o  out  1  one-cycle pulse: misaligned address, illegal funct3, or re&we together
- bus_re_o  out  1  word read request to bus interface
- bus_we_o  out  1  word write request to bus interface
- bus_addr_o  out  ADDR_W  {addr[31:2],2'b00}, held for the whole operation
- bus_wdata_o  out  DATA_W  write word; 0 when bus_we_o=0
- bus_rdata_i  in  DATA_W  read word; valid when bus_done_i=1
- bus_done_i  in  1  one-cycle pulse, current bus access completed

## Operation
- State register with states IDLE, LOAD, STORE, RMW_RD, RMW_WR.
- Internal flag done_r.
- Start condition, evaluated in IDLE only: (mem_re_i|mem_we_i) & !done_r.
- On start, capture addr, funct3 and wdata into operation registers. Illegal or misaligned requests raise err_o instead of starting.
- Request checks:
  - Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠0.
  - Illegal funct3: loads 011/110/111; stores with funct3[2]=1.
  - mem_re_i & mem_we_i both high is an error.
  - On any error: err_o pulses next cycle, no bus activity, done_r is set.
- Transitions from IDLE on a valid start:
  - Load → LOAD.
  - SW → STORE.
  - SB/SH → RMW_RD.
- LOAD: bus_re_o=1. On bus_done_i, register the extracted word into load_data_o, pulse load_valid_o next cycle, go to IDLE, set done_r.
- Load extraction:
  - LB/LBU use byte lane addr[1:0].
  - LH/LHU use the half selected by addr[1].
  - Sign extension for B/H; zero extension for BU/HU.
- RMW_RD: bus_re_o=1. On bus_done_i, merge into a word buffer, then go to RMW_WR.
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
- RMW_WR: bus_we_o=1, bus_wdata_o = merged word. On bus_done_i go to IDLE and set done_r.
- STORE: bus_we_o=1, bus_wdata_o = captured wdata. On bus_done_i go to IDLE and set done_r.
- done_r is cleared at the first edge where stall_i[4]=0. This prevents re-issuing the same instruction while the stage is still held.
- load_data_o holds its value until the next load completes.

## Timing
- Reset values: state=IDLE, done_r=0, load_data_o=0, and all other outputs 0.
- Reset taken in any state returns to IDLE at that edge; bus_re_o and bus_we_o are 0 the next cycle.
- bus_re_o, bus_we_o, bus_addr_o and bus_wdata_o are registered from state. They assert the cycle after start and stay stable until the bus_done_i edge.
- stallreq_o is combinational: (IDLE & start & no error) | (state≠IDLE).
- Latencies with bus_done_i arriving N cycles after request assert:
  - Load/SW: the stall is released N+1 cycles after start.
  - SB/SH: two bus accesses, no idle cycle between the read completion and the write request.
- bus_done_i seen in IDLE is ignored.
- bus_re_o and bus_we_o are never high together.

## Structure
- Shared in defines.v: funct3 load/store codes, LSU state encodings, and `MEM_DATA_BUS / `MEM_ADDR_BUS widths.
- One combinational sub-module, lsu_byte_lane, provides both functions: load extract/extend, and store merge (old word, new data, addr[1:0], funct3 → merged word).

## Test plan
- LW addr 0x100, bus_rdata_i=0xDEADBEEF, done after 2 cycles → bus_addr_o=0x100, load_data_o=0xDEADBEEF, single load_valid_o pulse, stallreq_o low 3 cycles after start.
- LB addr 0x103, rdata 0x80FF_1234 → load_data_o=0xFFFFFF80. LBU at the same address → 0x00000080. LHU addr 0x102 → 0x000080FF.
- SB addr 0x201, wdata 0xAA, read returns 0x11223344 → one read, then a write of 0x1122AA44 to 0x200; stallreq_o held throughout.
- SH addr 0x203 → err_o pulse, no bus_re_o/bus_we_o, stallreq_o stays 0. LW with funct3=011 → err_o.
- SW completes while stall_i[4]=1 for 3 more cycles with the request still present → no second bus_we_o. A new SW after stall_i[4]=0 is accepted.
- rst_n low during RMW_WR → bus_we_o=0 next cycle, state IDLE, load_data_o=0, no write completes.

Source files
------------

// File: rtl/lsu_mem_access_pkg.sv
// Shared load/store definitions: funct3 codes, LSU states, bus widths and request checking.
package lsu_mem_access_pkg;

   localparam int unsigned MemDataW = 32;
   localparam int unsigned MemAddrW = 32;

   localparam logic [2:0] F3Byte  = 3'b000;
   localparam logic [2:0] F3Half  = 3'b001;
   localparam logic [2:0] F3Word  = 3'b010;
   localparam logic [2:0] F3ByteU = 3'b100;
   localparam logic [2:0] F3HalfU = 3'b101;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StStore,
      StRmwRd,
      StRmwWr
   } lsu_state_e;

   // Returns 1 when a request must be refused: re&we together, illegal funct3 or misaligned.
   // RV32 has no doubleword store, so store funct3 011 is refused along with funct3[2]=1.
   function automatic logic req_error(input logic       re,
                                      input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      if (re && we) begin
         bad = 1'b1;
      end else if (re) begin
         case (funct3)
            F3Byte, F3ByteU: bad = 1'b0;
            F3Half, F3HalfU: bad = addr_lo[0];
            F3Word:          bad = (addr_lo != 2'b00);
            default:         bad = 1'b1;
         endcase
      end else if (we) begin
         case (funct3)
            F3Byte:  bad = 1'b0;
            F3Half:  bad = addr_lo[0];
            F3Word:  bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/lsu_mem_access_byte_lane.sv
// Byte-lane steering: load extract/extend and sub-word store merge into an old word.
module lsu_mem_access_byte_lane
   import lsu_mem_access_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [15:0] wdata_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        sign_ext;

   // Select the addressed byte or half of the read word and extend it.
   always_comb begin
      byte_sel = 8'h00;
      unique case (addr_lo_i)
         2'd0: byte_sel = rdata_i[7:0];
         2'd1: byte_sel = rdata_i[15:8];
         2'd2: byte_sel = rdata_i[23:16];
         2'd3: byte_sel = rdata_i[31:24];
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      sign_ext = ~funct3_i[2];
      case (funct3_i[1:0])
         2'b00:   load_data_o = {{24{sign_ext & byte_sel[7]}}, byte_sel};
         2'b01:   load_data_o = {{16{sign_ext & half_sel[15]}}, half_sel};
         default: load_data_o = rdata_i;
      endcase
   end

   // Overlay store data onto the old word in the addressed byte or half.
   always_comb begin
      merged_o = rdata_i;
      if (funct3_i == F3Half) begin
         if (addr_lo_i[1]) merged_o[31:16] = wdata_i;
         else              merged_o[15:0]  = wdata_i;
      end else begin
         unique case (addr_lo_i)
            2'd0: merged_o[7:0]   = wdata_i[7:0];
            2'd1: merged_o[15:8]  = wdata_i[7:0];
            2'd2: merged_o[23:16] = wdata_i[7:0];
            2'd3: merged_o[31:24] = wdata_i[7:0];
         endcase
      end
   end

endmodule

// File: rtl/lsu_mem_access.sv
// MEM-stage load/store unit: word-only bus requests, read-modify-write for sub-word stores.
module lsu_mem_access
   import lsu_mem_access_pkg::*;
#(
   parameter int unsigned ADDR_W = MemAddrW,
   parameter int unsigned DATA_W = MemDataW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_re_i,
   input  logic              mem_we_i,
   input  logic [2:0]        mem_funct3_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic [5:0]        stall_i,
   output logic              stallreq_o,
   output logic [DATA_W-1:0] load_data_o,
   output logic              load_valid_o,
   output logic              err_o,
   output logic              bus_re_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic [DATA_W-1:0] bus_rdata_i,
   input  logic              bus_done_i
);

   lsu_state_e  state_q;
   logic        done_r;
   logic [1:0]  addr_lo_q;
   logic [2:0]  funct3_q;
   logic [15:0] wdata_q;

   logic        start;
   logic        start_err;
   logic [31:0] lane_load;
   logic [31:0] lane_merged;
   logic        unused_stall;

   // Only the MEM-stage hold bit matters here.
   assign unused_stall = ^{stall_i[5], stall_i[3:0]};

   // done_r blocks re-issue of an instruction still parked in EX/MEM after it finished.
   assign start      = (mem_re_i | mem_we_i) & ~done_r;
   assign start_err  = req_error(mem_re_i, mem_we_i, mem_funct3_i, mem_addr_i[1:0]);
   assign stallreq_o = ((state_q == StIdle) & start & ~start_err) | (state_q != StIdle);

   lsu_mem_access_byte_lane u_byte_lane (
      .rdata_i     (bus_rdata_i),
      .wdata_i     (wdata_q),
      .addr_lo_i   (addr_lo_q),
      .funct3_i    (funct3_q),
      .load_data_o (lane_load),
      .merged_o    (lane_merged)
   );

   // Operation FSM with registered bus and result outputs; bus_wdata_o doubles as merge buffer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         done_r       <= 1'b0;
         addr_lo_q    <= 2'b00;
         funct3_q     <= 3'b000;
         wdata_q      <= 16'h0000;
         load_data_o  <= '0;
         load_valid_o <= 1'b0;
         err_o        <= 1'b0;
         bus_re_o     <= 1'b0;
         bus_we_o     <= 1'b0;
         bus_addr_o   <= '0;
         bus_wdata_o  <= '0;
      end else begin
         err_o        <= 1'b0;
         load_valid_o <= 1'b0;
         if (!stall_i[4]) done_r <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (start_err) begin
                     err_o  <= 1'b1;
                     done_r <= 1'b1;
                  end else begin
                     addr_lo_q  <= mem_addr_i[1:0];
                     funct3_q   <= mem_funct3_i;
                     wdata_q    <= mem_wdata_i[15:0];
                     bus_addr_o <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                     if (mem_re_i) begin
                        state_q  <= StLoad;
                        bus_re_o <= 1'b1;
                     end else if (mem_funct3_i == F3Word) begin
                        state_q     <= StStore;
                        bus_we_o    <= 1'b1;
                        bus_wdata_o <= mem_wdata_i;
                     end else begin
                        state_q  <= StRmwRd;
                        bus_re_o <= 1'b1;
                     end
                  end
               end
            end
            StLoad: begin
               if (bus_done_i) begin
                  load_data_o  <= lane_load;
                  load_valid_o <= 1'b1;
                  bus_re_o     <= 1'b0;
                  done_r       <= 1'b1;
                  state_q      <= StIdle;
               end
            end
            StStore, StRmwWr: begin
               if (bus_done_i) begin
                  bus_we_o    <= 1'b0;
                  bus_wdata_o <= '0;
                  done_r      <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            StRmwRd: begin
               if (bus_done_i) begin
                  bus_re_o    <= 1'b0;
                  bus_we_o    <= 1'b1;
                  bus_wdata_o <= lane_merged;
                  state_q     <= StRmwWr;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Self-checking bench: directed vector table, reset-in-RMW sequence and random ops vs a model.
module tb_lsu_mem_access;

   logic        clk;
   logic        rst_n;
   logic        mem_re_i;
   logic        mem_we_i;
   logic [2:0]  mem_funct3_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [5:0]  stall_i;
   logic        stallreq_o;
   logic [31:0] load_data_o;
   logic        load_valid_o;
   logic        err_o;
   logic        bus_re_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;
   logic        bus_done_i;

   int total;
   int bad;
   logic [31:0] model_load;

   lsu_mem_access #(
      .ADDR_W(32),
      .DATA_W(32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_re_i     (mem_re_i),
      .mem_we_i     (mem_we_i),
      .mem_funct3_i (mem_funct3_i),
      .mem_addr_i   (mem_addr_i),
      .mem_wdata_i  (mem_wdata_i),
      .stall_i      (stall_i),
      .stallreq_o   (stallreq_o),
      .load_data_o  (load_data_o),
      .load_valid_o (load_valid_o),
      .err_o        (err_o),
      .bus_re_o     (bus_re_o),
      .bus_we_o     (bus_we_o),
      .bus_addr_o   (bus_addr_o),
      .bus_wdata_o  (bus_wdata_o),
      .bus_rdata_i  (bus_rdata_i),
      .bus_done_i   (bus_done_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Reference rules, written as plain arithmetic on sizes and masks.
   function automatic bit ref_err(logic re, logic we, logic [2:0] f3, logic [31:0] addr);
      int unsigned size;
      if (re && we) return 1'b1;
      if (re && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
      if (we && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
      size = 32'd1 << f3[1:0];
      return (addr % size) != 0;
   endfunction

   function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] addr, logic [31:0] rd);
      int unsigned v;
      if (f3[1:0] == 2'd0) begin
         v = (rd >> (8 * addr[1:0])) & 32'hFF;
         if (!f3[2] && v >= 128) v = v - 256;
      end else if (f3[1:0] == 2'd1) begin
         v = (rd >> (16 * addr[1])) & 32'hFFFF;
         if (!f3[2] && v >= 32768) v = v - 65536;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_merge(logic [2:0] f3, logic [31:0] addr, logic [31:0] old,
                                             logic [31:0] wd);
      int unsigned mask;
      int unsigned sh;
      if (f3[1:0] == 2'd0) begin
         mask = 32'hFF;
         sh   = 8 * addr[1:0];
      end else begin
         mask = 32'hFFFF;
         sh   = 16 * addr[1];
      end
      return (old & ~(mask << sh)) | ((wd & mask) << sh);
   endfunction

   // One instruction through the MEM stage, with a bus that answers on the lat-th request cycle.
   // hold = extra cycles the stage stays held (request still present) after the LSU releases.
   task automatic do_op(input logic re, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int lat, input int hold,
                        input string tag, output logic [31:0] act_load,
                        output logic [31:0] act_wword, output int act_err);
      int stall_n, rd_n, wr_n, val_n, err_n, viol, age, phase, trail, hold_left;
      int e_rd, e_wr, e_val, e_stall;
      logic [31:0] rd_addr, wr_addr, wr_data, e_wword;
      bit e_err, finished;
      stall_n = 0; rd_n = 0; wr_n = 0; val_n = 0; err_n = 0; viol = 0; age = 0;
      phase = 0; trail = 0; hold_left = hold; finished = 0;
      rd_addr = '0; wr_addr = '0; wr_data = '0; e_wword = '0;
      e_err = ref_err(re, we, f3, addr);
      if (e_err) begin
         e_rd = 0; e_wr = 0; e_val = 0; e_stall = 0;
      end else if (re) begin
         e_rd = 1; e_wr = 0; e_val = 1; e_stall = lat + 1;
         model_load = ref_load(f3, addr, rdata);
      end else if (f3 == 3'd2) begin
         e_rd = 0; e_wr = 1; e_val = 0; e_stall = lat + 1;
         e_wword = wdata;
      end else begin
         e_rd = 1; e_wr = 1; e_val = 0; e_stall = 2 * lat + 1;
         e_wword = ref_merge(f3, addr, rdata, wdata);
      end

      @(negedge clk);
      mem_re_i = re; mem_we_i = we; mem_funct3_i = f3; mem_addr_i = addr; mem_wdata_i = wdata;
      for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
         #1;
         if (bus_re_o && bus_we_o) viol++;
         if (!bus_we_o && bus_wdata_o != 0) viol++;
         bus_done_i  = 1'b0;
         bus_rdata_i = $urandom;
         if (bus_re_o || bus_we_o) begin
            age++;
            if (age == lat) begin
               bus_done_i = 1'b1;
               age = 0;
               if (bus_re_o) begin
                  rd_n++; rd_addr = bus_addr_o; bus_rdata_i = rdata;
               end else begin
                  wr_n++; wr_addr = bus_addr_o; wr_data = bus_wdata_o;
               end
            end
         end
         if (err_o) err_n++;
         if (load_valid_o) val_n++;
         if (stallreq_o) stall_n++;
         if (phase == 0 && !stallreq_o) phase = 1;
         if (phase == 1 && hold_left == 0) phase = 2;
         stall_i = (phase <= 1) ? 6'h1F : 6'h00;
         if (phase == 1) hold_left--;
         @(negedge clk);
         if (phase == 2) begin
            mem_re_i = 1'b0; mem_we_i = 1'b0; phase = 3;
         end else if (phase == 3) begin
            trail++;
            if (trail == 3) finished = 1;
         end
      end
      bus_done_i = 1'b0;
      stall_i    = 6'h00;
      mem_re_i   = 1'b0;
      mem_we_i   = 1'b0;
      if (!finished) begin
         total++; bad++;
         $display("FAIL %s timeout: got no release in 200 cycles, required release", tag);
      end
      chk({tag, " err_pulses"}, err_n, e_err ? 1 : 0);
      chk({tag, " valid_pulses"}, val_n, e_val);
      chk({tag, " bus_reads"}, rd_n, e_rd);
      chk({tag, " bus_writes"}, wr_n, e_wr);
      chk({tag, " stall_cycles"}, stall_n, e_stall);
      chk({tag, " bus_protocol_violations"}, viol, 0);
      if (e_rd == 1) chk({tag, " read_addr"}, rd_addr, addr & 32'hFFFF_FFFC);
      if (e_wr == 1) begin
         chk({tag, " write_addr"}, wr_addr, addr & 32'hFFFF_FFFC);
         chk({tag, " write_data"}, wr_data, e_wword);
      end
      chk({tag, " load_data"}, load_data_o, model_load);
      act_load  = load_data_o;
      act_wword = wr_data;
      act_err   = err_n;
   endtask

   typedef struct {
      logic        re;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
      int          hold;
      logic [31:0] exp_load;
      logic        exp_err;
      logic [31:0] exp_wword;
   } vec_t;

   function automatic vec_t mk(logic re, logic we, logic [2:0] f3, logic [31:0] addr,
                               logic [31:0] wdata, logic [31:0] rdata, int lat, int hold,
                               logic [31:0] exp_load, logic exp_err, logic [31:0] exp_wword);
      vec_t v;
      v.re = re; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.lat = lat; v.hold = hold; v.exp_load = exp_load; v.exp_err = exp_err;
      v.exp_wword = exp_wword;
      return v;
   endfunction

   initial begin
      vec_t vecs[12];
      logic [31:0] a_load, a_wword;
      int a_err, age, wcnt;
      bit seen;

      total = 0; bad = 0; model_load = '0;
      rst_n = 1'b0; mem_re_i = 1'b0; mem_we_i = 1'b0; mem_funct3_i = 3'b0;
      mem_addr_i = '0; mem_wdata_i = '0; stall_i = 6'h00; bus_rdata_i = '0; bus_done_i = 1'b0;

      vecs[0]  = mk(1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 2, 0,
                    32'hDEADBEEF, 0, 32'h0);
      vecs[1]  = mk(1, 0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 1, 0,
                    32'hFFFFFF80, 0, 32'h0);
      vecs[2]  = mk(1, 0, 3'b100, 32'h103, 32'h0,        32'h80FF1234, 3, 0,
                    32'h00000080, 0, 32'h0);
      vecs[3]  = mk(1, 0, 3'b101, 32'h102, 32'h0,        32'h80FF1234, 2, 0,
                    32'h000080FF, 0, 32'h0);
      vecs[4]  = mk(0, 1, 3'b000, 32'h201, 32'hAA,       32'h11223344, 2, 0,
                    32'h000080FF, 0, 32'h1122AA44);
      vecs[5]  = mk(0, 1, 3'b001, 32'h203, 32'h5555,     32'h0,        2, 0,
                    32'h000080FF, 1, 32'h0);
      vecs[6]  = mk(1, 0, 3'b011, 32'h100, 32'h0,        32'h0,        2, 0,
                    32'h000080FF, 1, 32'h0);
      vecs[7]  = mk(0, 1, 3'b010, 32'h300, 32'h12345678, 32'h0,        1, 3,
                    32'h000080FF, 0, 32'h12345678);
      vecs[8]  = mk(0, 1, 3'b010, 32'h304, 32'hCAFEF00D, 32'h0,        3, 0,
                    32'h000080FF, 0, 32'hCAFEF00D);
      vecs[9]  = mk(1, 0, 3'b001, 32'h102, 32'h0,        32'h80FF1234, 2, 1,
                    32'hFFFF80FF, 0, 32'h0);
      vecs[10] = mk(1, 1, 3'b010, 32'h100, 32'h0,        32'h0,        2, 0,
                    32'hFFFF80FF, 1, 32'h0);
      vecs[11] = mk(0, 1, 3'b001, 32'h202, 32'hBEEF,     32'h11223344, 1, 0,
                    32'hFFFF80FF, 0, 32'hBEEF3344);

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("reset bus_re", bus_re_o, 0);
      chk("reset bus_we", bus_we_o, 0);
      chk("reset bus_addr", bus_addr_o, 0);
      chk("reset bus_wdata", bus_wdata_o, 0);
      chk("reset load_data", load_data_o, 0);
      chk("reset load_valid", load_valid_o, 0);
      chk("reset err", err_o, 0);
      chk("reset stallreq", stallreq_o, 0);
      rst_n = 1'b1;

      // Directed vectors
      for (int i = 0; i < 12; i++) begin
         do_op(vecs[i].re, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
               vecs[i].lat, vecs[i].hold, $sformatf("vec%0d", i), a_load, a_wword, a_err);
         chk($sformatf("vec%0d table_load", i), a_load, vecs[i].exp_load);
         chk($sformatf("vec%0d table_err", i), a_err, {31'b0, vecs[i].exp_err});
         if (vecs[i].we && !vecs[i].exp_err)
            chk($sformatf("vec%0d table_wword", i), a_wword, vecs[i].exp_wword);
      end

      // Reset while the RMW write is outstanding
      @(negedge clk);
      mem_re_i = 1'b0; mem_we_i = 1'b1; mem_funct3_i = 3'b000;
      mem_addr_i = 32'h201; mem_wdata_i = 32'hAA; stall_i = 6'h1F;
      age = 0; seen = 0;
      for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
         #1;
         bus_done_i = 1'b0;
         if (bus_we_o) begin
            seen = 1;
         end else begin
            if (bus_re_o) begin
               age++;
               if (age == 2) begin
                  bus_done_i = 1'b1; bus_rdata_i = 32'h11223344;
               end
            end
            @(negedge clk);
         end
      end
      chk("rmw_rst reached_write", {31'b0, seen}, 1);
      rst_n = 1'b0; mem_we_i = 1'b0; stall_i = 6'h00;
      @(negedge clk);
      #1;
      model_load = '0;
      chk("rmw_rst bus_we", bus_we_o, 0);
      chk("rmw_rst bus_re", bus_re_o, 0);
      chk("rmw_rst bus_wdata", bus_wdata_o, 0);
      chk("rmw_rst load_data", load_data_o, model_load);
      chk("rmw_rst stallreq", stallreq_o, 0);
      rst_n = 1'b1;
      wcnt = 0;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (bus_we_o) wcnt++;
      end
      chk("rmw_rst no_write_after", wcnt, 0);

      // Random instructions
      for (int n = 0; n < 40; n++) begin
         logic re, we;
         logic [2:0] f3;
         int kind;
         kind = $urandom_range(0, 9);
         re = (kind <= 4) || (kind == 9);
         we = (kind >= 5);
         if (re && !we) begin
            f3 = 3'($urandom_range(0, 7));
         end else begin
            f3 = 3'($urandom_range(0, 6));
            if (f3 == 3'd3) f3 = 3'd0;
         end
         do_op(re, we, f3, {20'h0, 10'($urandom), 2'($urandom)}, $urandom, $urandom,
               $urandom_range(1, 4), $urandom_range(0, 2), $sformatf("rnd%0d", n),
               a_load, a_wword, a_err);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
